// File: rtl/uart_in_byte_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_in_byte_pkg                                          |
// | Purpose  : Shared types and constants for the uart_in_byte console   |
// |            receiver: receiver FSM state encoding, register offsets   |
// |            within the block, and STATUS register bit positions.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_in_byte_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Register offsets within the 8-byte block (low three address bits)
    localparam logic [2:0] DATA_OFF   = 3'h0;
    localparam logic [2:0] STATUS_OFF = 3'h4;

    // STATUS register bit positions
    localparam int NONEMPTY  = 0;
    localparam int FULL      = 1;
    localparam int OVERFLOW  = 2;
    localparam int FRAMING   = 3;
    localparam int COUNT_LSB = 8;

    // The STATUS count field is only four bits wide; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage : uart_in_byte_pkg
`default_nettype wire

// File: rtl/uart_in_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : byte_fifo                                                 |
// | Purpose  : Synchronous show-ahead FIFO. Pointers carry one extra     |
// |            wrap bit so full and empty are distinguished without a    |
// |            separate counter.                                         |
// | Ports    : clk, resetn (async, active low)                           |
// |            push/din  - write request and data                        |
// |            pop       - read request (dout already shows the head)    |
// |            dout      - head entry, meaningful only when !empty       |
// |            empty, full, count (0..DEPTH)                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees the slot in the same cycle, so a simultaneous push into a
    // full FIFO is accepted. Popping an empty FIFO does nothing.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/uart_in_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_in_byte                                              |
// | Purpose  : Console input for the picorv32 system. Receives 8N1       |
// |            frames on rx, buffers bytes in a FIFO and exposes them    |
// |            as DATA (+0x0) and STATUS (+0x4) registers on the native  |
// |            mem_* bus.                                                |
// | Ports    : clk, resetn (async, active low), rx (async serial in)     |
// |            mem_valid/addr/wstrb/wdata -> mem_ready/mem_rdata         |
// |            in_byte/in_byte_en - per-byte strobe for monitoring       |
// |            irq - high while the FIFO holds data                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_in_byte
    import uart_in_byte_pkg::*;
#(
    parameter int          CLK_DIV    = 104,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  in_byte,
    output logic        in_byte_en,
    output logic        irq
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_full_bit = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_half_bit = CNT_W'(CLK_DIV / 2 - 1);

    // ---------------- receiver ----------------
    logic             r_rx_meta, r_rx_s;
    rx_state_t        r_state, w_state_next;
    logic [CNT_W-1:0] r_bit_cnt, w_cnt_next;
    logic [2:0]       r_bit_idx, w_idx_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             w_push, w_frame_set;

    // ---------------- fifo / bus ----------------
    logic [7:0]       w_fifo_dout;
    logic             w_empty, w_full;
    logic [FCW-1:0]   w_count;
    logic             w_sel, w_rd, w_is_data, w_is_status, w_pop, w_status_wr;
    logic             w_ovf_set;
    logic [31:0]      w_status, w_rdata_next;
    logic             r_overflow, r_framing;
    logic             r_mem_ready;
    logic [31:0]      r_mem_rdata;
    logic [7:0]       r_in_byte;
    logic             r_in_byte_en;

    // Synchronizer idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_bit_idx <= w_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // Half-bit wait in START puts every later sample near mid-bit.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_frame_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                    w_cnt_next   = c_half_bit;
                end
            end
            ST_START: begin
                if (r_bit_cnt != '0) begin
                    w_cnt_next = r_bit_cnt - 1'b1;
                end else if (!r_rx_s) begin
                    w_state_next = ST_DATA;
                    w_cnt_next   = c_full_bit;
                    w_idx_next   = 3'd0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (r_bit_cnt != '0) begin
                    w_cnt_next = r_bit_cnt - 1'b1;
                end else begin
                    w_shift_next = {r_rx_s, r_shift[7:1]};
                    w_cnt_next   = c_full_bit;
                    if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
                    else                   w_idx_next   = r_bit_idx + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_bit_cnt != '0) begin
                    w_cnt_next = r_bit_cnt - 1'b1;
                end else if (r_rx_s) begin
                    w_push       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_frame_set  = 1'b1;
                    w_state_next = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                // Line held low (break): wait for idle so it is one error only.
                if (r_rx_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    (r_shift),
        .dout   (w_fifo_dout),
        .empty  (w_empty),
        .full   (w_full),
        .count  (w_count)
    );

    // Blocking the select while mem_ready is high prevents a second pop
    // when the master keeps mem_valid asserted through the acknowledge.
    assign w_sel       = mem_valid & ~r_mem_ready &
                         (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign w_is_data   = ({mem_addr[2], 2'b00} == DATA_OFF);
    assign w_is_status = ({mem_addr[2], 2'b00} == STATUS_OFF);
    assign w_rd        = w_sel & (mem_wstrb == 4'b0000);
    assign w_pop       = w_rd & w_is_data;
    assign w_status_wr = w_sel & w_is_status & mem_wstrb[0];
    // When full, a same-cycle pop makes room, so only an unpaired push drops.
    assign w_ovf_set   = w_push & w_full & ~w_pop;

    always_comb begin
        w_status = '0;
        w_status[NONEMPTY]         = ~w_empty;
        w_status[FULL]             = w_full;
        w_status[OVERFLOW]         = r_overflow;
        w_status[FRAMING]          = r_framing;
        w_status[COUNT_LSB +: 4]   = sat_count4(32'(w_count));
    end

    always_comb begin
        w_rdata_next = '0;
        if (w_rd) begin
            if (w_is_status)   w_rdata_next = w_status;
            else if (!w_empty) w_rdata_next = {1'b1, 23'b0, w_fifo_dout};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow   <= 1'b0;
            r_framing    <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_mem_rdata  <= '0;
            r_in_byte    <= '0;
            r_in_byte_en <= 1'b0;
        end else begin
            // Set takes priority over a same-cycle write-one-to-clear.
            r_overflow   <= w_ovf_set |
                            (r_overflow & ~(w_status_wr & mem_wdata[OVERFLOW]));
            r_framing    <= w_frame_set |
                            (r_framing & ~(w_status_wr & mem_wdata[FRAMING]));
            r_mem_ready  <= w_sel;
            r_mem_rdata  <= w_rdata_next;
            r_in_byte_en <= w_push;
            if (w_push) r_in_byte <= r_shift;
        end
    end

    assign mem_ready  = r_mem_ready;
    assign mem_rdata  = r_mem_rdata;
    assign in_byte    = r_in_byte;
    assign in_byte_en = r_in_byte_en;
    assign irq        = ~w_empty;

    // Bits with no function in this block
    logic w_unused_bits;
    assign w_unused_bits = ^{mem_addr[1:0], mem_wstrb[3:1],
                             mem_wdata[31:4], mem_wdata[1:0]};

endmodule : uart_in_byte
`default_nettype wire

// File: tb/tb_uart_in_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_in_byte                                           |
// | Purpose  : Directed self-checking bench for uart_in_byte with        |
// |            CLK_DIV=4, FIFO_DEPTH=8.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_in_byte;

    localparam int          CLK_DIV = 4;
    localparam logic [31:0] BASE    = 32'h2000_0000;
    localparam logic [31:0] A_DATA  = BASE + 32'h0;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        rx        = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  in_byte;
    logic        in_byte_en;
    logic        irq;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          en_count = 0;
    logic [7:0]  last_byte = '0;

    uart_in_byte #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (rx),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .in_byte    (in_byte),
        .in_byte_en (in_byte_en),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Strobe monitor: a pulse longer than one cycle counts more than once.
    always @(negedge clk) begin
        if (resetn && in_byte_en) begin
            en_count  = en_count + 1;
            last_byte = in_byte;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first and the given stop level; rx is
    // left at the stop level so a caller can extend a break.
    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CLK_DIV) @(negedge clk);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata,
                       output logic rdy, output logic [31:0] rdata);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = wdata;
        @(posedge clk);
        #1;
        rdy       = mem_ready;
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = '0;
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic        rdy;
        logic [31:0] d;
        bus(addr, 4'b0000, 32'h0, rdy, d);
        check({tag, "_rdy"}, {31'b0, rdy}, 32'h1);
        check(tag, d, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic        rdy;
        logic [31:0] d;
        bus(addr, 4'b0001, data, rdy, d);
        check({tag, "_rdy"}, {31'b0, rdy}, 32'h1);
    endtask

    initial begin
        int          en_before;
        logic        rdy;
        logic [31:0] d;
        logic [7:0]  part;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, mem_ready},  32'h0);
        check("rst_rdata", mem_rdata,           32'h0);
        check("rst_inbyte", {24'b0, in_byte},   32'h0);
        check("rst_en",    {31'b0, in_byte_en}, 32'h0);
        check("rst_irq",   {31'b0, irq},        32'h0);
        resetn = 1'b1;
        idle(4);

        // ---- single byte 0x55 ----
        send(8'h55, 1'b1);
        idle(8);
        check("b55_en_cnt", 32'(en_count), 32'd1);
        check("b55_byte", {24'b0, last_byte}, 32'h55);
        check("b55_irq", {31'b0, irq}, 32'h1);
        rd("b55_stat", A_STAT, 32'h0000_0101);
        rd("b55_data", A_DATA, 32'h8000_0055);
        rd("b55_stat2", A_STAT, 32'h0000_0000);
        check("b55_irq_clr", {31'b0, irq}, 32'h0);

        // ---- empty read, address miss ----
        rd("empty_data", A_DATA, 32'h0000_0000);
        rd("empty_stat", A_STAT, 32'h0000_0000);
        bus(BASE + 32'h8, 4'b0000, 32'h0, rdy, d);
        check("miss_rdy", {31'b0, rdy}, 32'h0);
        check("miss_rdata", d, 32'h0);

        // ---- overflow: nine bytes into eight entries ----
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 1'b1);
            idle(4);
        end
        idle(4);
        check("ovf_en_cnt", 32'(en_count), 32'd10);
        check("ovf_last", {24'b0, last_byte}, 32'h09);
        rd("ovf_stat", A_STAT, 32'h0000_0807);
        // first read holds mem_valid for two cycles: one acknowledge, one pop
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = A_DATA;
        mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        check("hold_rdy1", {31'b0, mem_ready}, 32'h1);
        check("hold_data1", mem_rdata, 32'h8000_0001);
        @(posedge clk);
        #1;
        check("hold_rdy2", {31'b0, mem_ready}, 32'h0);
        mem_valid = 1'b0;
        @(negedge clk);
        for (int i = 2; i <= 8; i++) begin
            rd("ovf_data", A_DATA, 32'h8000_0000 | 32'(i));
        end
        rd("ovf_stat_drained", A_STAT, 32'h0000_0004);
        wr("ovf_w1c", A_STAT, 32'h0000_0004);
        rd("ovf_stat_clr", A_STAT, 32'h0000_0000);

        // ---- framing error with a 3-bit-time break ----
        en_before = en_count;
        send(8'hA3, 1'b0);
        repeat (3 * CLK_DIV) @(negedge clk);
        idle(8);
        check("frm_no_en", 32'(en_count), 32'(en_before));
        rd("frm_stat", A_STAT, 32'h0000_0008);
        send(8'h3C, 1'b1);
        idle(8);
        check("frm_next_en", 32'(en_count), 32'(en_before + 1));
        check("frm_next_byte", {24'b0, last_byte}, 32'h3C);
        rd("frm_stat2", A_STAT, 32'h0000_0109);
        rd("frm_data", A_DATA, 32'h8000_003C);
        wr("frm_w1c", A_STAT, 32'h0000_0008);
        rd("frm_stat_clr", A_STAT, 32'h0000_0000);

        // ---- one-clock glitch ----
        en_before = en_count;
        rx = 1'b0;
        @(negedge clk);
        idle(3 * CLK_DIV * 10);
        check("glitch_en", 32'(en_count), 32'(en_before));
        check("glitch_irq", {31'b0, irq}, 32'h0);
        rd("glitch_stat", A_STAT, 32'h0000_0000);

        // ---- reset in the middle of data bit 4 ----
        send(8'h7E, 1'b1);
        idle(8);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        en_before = en_count;
        part = 8'hAA;
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = part[4];
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, mem_ready},  32'h0);
        check("mid_rst_rdata", mem_rdata,           32'h0);
        check("mid_rst_inbyte", {24'b0, in_byte},   32'h0);
        check("mid_rst_en",    {31'b0, in_byte_en}, 32'h0);
        check("mid_rst_irq",   {31'b0, irq},        32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle(3 * CLK_DIV * 10);
        check("post_rst_en", 32'(en_count), 32'(en_before));
        rd("post_rst_stat", A_STAT, 32'h0000_0000);
        send(8'hC3, 1'b1);
        idle(8);
        check("post_rst_byte", {24'b0, last_byte}, 32'hC3);
        check("post_rst_en2", 32'(en_count), 32'(en_before + 1));
        rd("post_rst_data", A_DATA, 32'h8000_00C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_in_byte
`default_nettype wire

// File: doc/uart_in_byte.md
Name: uart_in_byte

Overview:
- Console input path for the picorv32 system. It is the reader-side counterpart of the out_byte/out_byte_en console output.
- Receives 8N1 serial frames on rx and buffers the bytes in a small FIFO.
- Exposes the FIFO to the CPU as two memory-mapped registers on the native picorv32 mem_* bus.
- Also gives a per-byte strobe for testbench monitoring and a level irq.

Parameters:
- CLK_DIV, 104: clk cycles per serial bit. Must be ≥4.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of two, ≥2.
- BASE_ADDR, 32'h2000_0000: register block base address. Decode uses mem_addr[31:3].

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx  in  1  serial input, idles high, asynchronous to clk
- mem_valid  in  1  picorv32 bus request
- mem_addr  in  32  byte address
- mem_wstrb  in  4  write strobes; 0 = read
- mem_wdata  in  32  write data
- mem_ready  out  1  one-cycle acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1
- in_byte  out  8  last byte received with a good stop bit
- in_byte_en  out  1  one-cycle strobe qualifying in_byte
- irq  out  1  high while FIFO non-empty

Behaviour:
- Reset values:
  - mem_ready=0, mem_rdata=0, in_byte=0, in_byte_en=0, irq=0.
  - FIFO empty; sticky flags 0; FSM IDLE; rx synchronizer flops =1.
  - Reset mid-frame aborts the frame; nothing is pushed.
- rx passes through a 2-flop synchronizer. rx_s below denotes the synchronized value.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. bit_cnt counts 0..CLK_DIV-1.
  - IDLE: rx_s=0 → START, cnt=CLK_DIV/2-1.
  - START: at cnt=0, if rx_s=0 → DATA, cnt=CLK_DIV-1, bit index 0. If rx_s=1 → IDLE (glitch rejected).
  - DATA: at each cnt=0, shift rx_s in LSB first. After bit 7 → STOP, cnt=CLK_DIV-1.
  - STOP: at cnt=0, if rx_s=1:
    - push the byte;
    - in_byte ← byte and in_byte_en=1 for one cycle, even if the FIFO is full;
    - → IDLE.
  - STOP, if rx_s=0: set framing_err, discard the byte, → WAIT_HIGH.
  - WAIT_HIGH: rx_s=1 → IDLE. Break conditions therefore produce one framing error, not repeated frames.
- FIFO:
  - Push while full and no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pop while empty: no-op, no underflow state.
  - irq = ~empty.
- Registers (offset from BASE_ADDR):
  - 0x0 DATA. Read: {valid, 23'b0, head byte}. valid=1 and head popped if non-empty; otherwise 0x0000_0000. Writes are acknowledged and ignored.
  - 0x4 STATUS. Read: {16'b0, 4'b0, count[3:0] saturated to 15, 4'b0, framing_err, overflow, full, nonempty}, i.e. count in bits 11:8.
  - 0x4 STATUS write, with mem_wstrb[0]=1: wdata[2]=1 clears overflow; wdata[3]=1 clears framing_err (W1C).
  - STATUS W1C in the same cycle as a new set event: the set wins.
- Bus timing:
  - mem_valid with an address hit at edge N → mem_ready=1 and mem_rdata registered at edge N+1. The pop/W1C takes effect at edge N+1.
  - mem_ready is a single-cycle pulse. No new acknowledge is issued in the cycle mem_ready is high, even if mem_valid is still high, so there is no double pop.
  - Address miss: mem_ready stays 0 and mem_rdata=0 (the system ORs slaves).
- A pop at the same edge as a push into an empty FIFO: the read returns 0, and the pushed byte remains.

Decomposition:
- Package uart_in_byte_pkg holds:
  - the FSM state enum;
  - register offsets DATA_OFF=0, STATUS_OFF=4;
  - STATUS bit indices NONEMPTY=0, FULL=1, OVERFLOW=2, FRAMING=3, COUNT_LSB=8.
- One sub-module: byte_fifo. It is a synchronous FIFO with WIDTH=8 and DEPTH parameters; ports push, pop, din, dout, empty, full, count. It uses show-ahead dout and the pointer+extra-bit full/empty scheme.
- Receiver FSM and bus decode stay in the top.

Test Plan: (all with CLK_DIV=4, FIFO_DEPTH=8)
- Send frame 0x55 → exactly one in_byte_en pulse with in_byte=0x55 and irq=1. Read 0x4 → 0x0000_0101. Read 0x0 → 0x8000_0055. Read 0x4 → 0x0000_0000, irq=0.
- Read DATA while empty → mem_ready after 1 cycle, rdata 0x0000_0000. STATUS unchanged.
- Send 0x01..0x09 with no reads → STATUS 0x0000_0807 (count 8, overflow, full, nonempty). Eight DATA reads return 0x80000001..0x80000008 in order. Write 0x4 ← 0x4 → overflow clears.
- Send 0xA3 with stop bit 0 and hold rx low 3 bit times → framing_err=1, no push, no in_byte_en. Release rx, send 0x3C → 0x3C received correctly.
- rx low for 1 clk (under half a bit) → no state change beyond START, no byte, FIFO empty.
- Assert resetn=0 during DATA bit 4 → all outputs 0 and FIFO empty. Release, send 0xC3 → received 0xC3.
